// File: rtl/dmem_pkg.sv
// Shared access-type encodings, FSM states and decode helpers for the data memory unit.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LD  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] LWU = 3'd6;

    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;
    localparam logic [2:0] SD  = 3'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } dmem_state_e;

    function automatic logic [3:0] size_from_type(input logic [2:0] acc_type);
        logic [3:0] size;
        case (acc_type[1:0])
            2'd0:    size = 4'd1;
            2'd1:    size = 4'd2;
            2'd2:    size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

    // Doubleword accesses and LWU only exist on a 64-bit datapath.
    function automatic logic type_legal(input logic is_write, input logic [2:0] acc_type,
                                        input int xlen);
        logic legal;
        if (is_write) begin
            legal = (acc_type inside {SB, SH, SW}) || ((acc_type == SD) && (xlen == 64));
        end else begin
            legal = (acc_type inside {LB, LH, LW, LBU, LHU}) ||
                    ((acc_type inside {LD, LWU}) && (xlen == 64));
        end
        return legal;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [2:0] acc_type);
        logic [2:0] mask;
        mask = 3'(size_from_type(acc_type) - 4'd1);
        return (addr_lo & mask) != 3'd0;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Turns a little-endian gathered word into an XLEN load result with sign or zero extension.
module dmem_load_extend
    import dmem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      load_type,
    output logic [XLEN-1:0] data
);

    // Unsupported codes (including 64-bit-only ones on a 32-bit build) yield zero.
    always_comb begin
        data = '0;
        case (load_type)
            LB:      data = XLEN'($signed(raw[7:0]));
            LH:      data = XLEN'($signed(raw[15:0]));
            LW:      data = XLEN'($signed(raw[31:0]));
            LBU:     data = XLEN'(raw[7:0]);
            LHU:     data = XLEN'(raw[15:0]);
            LWU:     data = (XLEN == 64) ? XLEN'(raw[31:0]) : '0;
            LD:      data = (XLEN == 64) ? raw : '0;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressable data memory: checked load/store port A, read-only snoop port B
// and a bulk-clear engine that zeroes one XLEN-wide block per cycle.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int    XLEN        = 64,
    parameter int    MEM_BITS    = 12,
    parameter bit    ALIGN_CHECK = 1'b1,
    parameter string INIT_FILE   = ""
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_type,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    input  logic            rd2_en,
    input  logic [2:0]      rd2_type,
    input  logic [XLEN-1:0] rd2_addr,
    output logic [XLEN-1:0] rd2_data,
    input  logic            clear_start,
    output logic            busy,
    output logic            clear_done
);

    localparam int NBYTES   = XLEN / 8;
    localparam int BLK_BITS = $clog2(NBYTES);
    localparam int PTR_BITS = MEM_BITS - BLK_BITS;
    localparam int DEPTH    = 1 << MEM_BITS;

    logic [7:0] mem [DEPTH];

    dmem_state_e          state_r;
    logic [PTR_BITS-1:0]  clr_ptr_r;
    logic                 busy_r;
    logic                 clear_done_r;
    logic                 resp_valid_r;
    logic                 resp_err_r;
    logic [XLEN-1:0]      resp_rdata_r;
    logic [XLEN-1:0]      rd2_data_r;

    logic [MEM_BITS-1:0]  a_addr_s;
    logic [MEM_BITS-1:0]  b_addr_s;
    logic [XLEN-1:0]      a_raw_s;
    logic [XLEN-1:0]      b_raw_s;
    logic [XLEN-1:0]      a_ext_s;
    logic [XLEN-1:0]      b_ext_s;
    logic [3:0]           a_size_s;
    logic                 accept_s;
    logic                 a_err_s;
    logic                 store_s;
    logic                 unused_addr_s;

    // Upper address bits alias onto the array.
    assign a_addr_s      = req_addr[MEM_BITS-1:0];
    assign b_addr_s      = rd2_addr[MEM_BITS-1:0];
    assign unused_addr_s = ^{req_addr[XLEN-1:MEM_BITS], rd2_addr[XLEN-1:MEM_BITS]};

    // A clear request in the same cycle takes priority over a port A request.
    assign req_ready = (state_r == IDLE) && !clear_start;
    assign accept_s  = req_valid && req_ready;
    assign a_size_s  = size_from_type(req_type);
    assign a_err_s   = !type_legal(req_write, req_type, XLEN) ||
                       (ALIGN_CHECK && is_misaligned(a_addr_s[2:0], req_type));
    assign store_s   = accept_s && req_write && !a_err_s;

    // Gather consecutive bytes for each port, wrapping at the top of the array.
    always_comb begin
        a_raw_s = '0;
        b_raw_s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            a_raw_s[8*i +: 8] = mem[a_addr_s + MEM_BITS'(i)];
            b_raw_s[8*i +: 8] = mem[b_addr_s + MEM_BITS'(i)];
        end
    end

    dmem_load_extend #(.XLEN(XLEN)) u_extend_a (
        .raw       (a_raw_s),
        .load_type (req_type),
        .data      (a_ext_s)
    );

    dmem_load_extend #(.XLEN(XLEN)) u_extend_b (
        .raw       (b_raw_s),
        .load_type (rd2_type),
        .data      (b_ext_s)
    );

    // Array write port: committed stores, otherwise one zeroed block per clear cycle.
    always_ff @(posedge clock) begin
        if (store_s) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (4'(i) < a_size_s) begin
                    mem[a_addr_s + MEM_BITS'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end else if (state_r == CLEAR) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem[{clr_ptr_r, BLK_BITS'(i)}] <= 8'd0;
            end
        end
    end

    // Port A response: one-cycle strobe, data/error held until the next response.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
        end else begin
            resp_valid_r <= accept_s;
            if (accept_s) begin
                resp_err_r   <= a_err_s;
                resp_rdata_r <= (a_err_s || req_write) ? '0 : a_ext_s;
            end
        end
    end

    // Port B snoop read; sees the array before any same-edge store lands.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rd2_data_r <= '0;
        end else begin
            rd2_data_r <= rd2_en ? b_ext_s : '0;
        end
    end

    // Bulk-clear sequencer: sweeps blocks upward from zero, done pulse after the last one.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            clr_ptr_r    <= '0;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    clear_done_r <= 1'b0;
                    if (clear_start) begin
                        state_r   <= CLEAR;
                        clr_ptr_r <= '0;
                        busy_r    <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + PTR_BITS'(1);
                    if (clr_ptr_r == '1) begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        clear_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    clear_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    assign rd2_data   = rd2_data_r;
    assign busy       = busy_r;
    assign clear_done = clear_done_r;

endmodule
